// File: rtl/csr_pkg.sv
// Shared CSR addresses, write-op encoding and the read-modify-write helper.
package csr_pkg;

  // Fixed machine/user counter and control CSR addresses
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  // New CSR value for a given op; callers truncate to their data width.
  function automatic logic [63:0] csr_rmw(input csr_op_e op, input logic [63:0] old,
                                          input logic [63:0] src);
    case (op)
      CSR_RW:  return src;
      CSR_RS:  return old | src;
      CSR_RC:  return old & ~src;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Wide event counter with inhibit and split low/high word writes.
// A write on an edge takes priority over that edge's increment.
module csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 inhibit,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [CNT_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] write_next;

  // Merge the written half into the current value, keeping the other half
  always_comb begin
    write_next = count_reg;
    if (wr_lo) write_next[31:0] = wr_data[31:0];
    if (wr_hi) write_next[CNT_WIDTH-1:32] = wr_data[CNT_WIDTH-1:32];
  end

  // Counter register: write beats increment, full-width add so carry is immediate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (wr_lo || wr_hi) begin
      count_reg <= write_next;
    end else if (inc && !inhibit) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/csr_unit.sv
// CSR file: scratch registers, mcountinhibit, mcycle/minstret with user
// shadows. Combinational ID read with WB write-through; RMW done at WB.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [11:0] SCRATCH_BASE = 12'h340,
  parameter int          CNT_WIDTH    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [1:0]      wr_op,
  input  logic [XLEN-1:0] wr_src,
  input  logic            retire,
  output logic            wr_illegal
);

  logic [XLEN-1:0]      scratch_reg [NUM_SCRATCH];
  logic                 inhibit_cy_reg;
  logic                 inhibit_ir_reg;
  logic                 wr_illegal_reg;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instret_cnt;
  logic [63:0]          cycle_ext;
  logic [63:0]          instret_ext;

  csr_op_e         op;
  logic            wr_effective;
  logic            wr_commit;
  logic            wr_bad;
  logic [XLEN-1:0] wr_new;
  logic [XLEN-1:0] wr_vis;
  logic [63:0]     cnt_wdata;
  logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  // Counter bits above CNT_WIDTH read as zero
  assign cycle_ext   = 64'(cycle_cnt);
  assign instret_ext = 64'(instret_cnt);

  function automatic logic csr_mapped(input logic [11:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (addr == SCRATCH_BASE + 12'(i)) hit = 1'b1;
    case (addr)
      CSR_MCOUNTINHIBIT, CSR_MCYCLE, CSR_MINSTRET, CSR_CYCLE, CSR_INSTRET: hit = 1'b1;
      CSR_MCYCLEH, CSR_MINSTRETH, CSR_CYCLEH, CSR_INSTRETH: hit = (XLEN == 32);
      default: ;
    endcase
    return hit;
  endfunction

  // User-level 0xCxx space is read-only
  function automatic logic csr_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

  function automatic logic [XLEN-1:0] csr_value(input logic [11:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (addr == SCRATCH_BASE + 12'(i)) val = scratch_reg[i];
    case (addr)
      CSR_MCOUNTINHIBIT:           val = XLEN'({inhibit_ir_reg, 1'b0, inhibit_cy_reg});
      CSR_MCYCLE, CSR_CYCLE:       val = XLEN'(cycle_ext);
      CSR_MINSTRET, CSR_INSTRET:   val = XLEN'(instret_ext);
      CSR_MCYCLEH, CSR_CYCLEH:     val = XLEN'(cycle_ext[63:32]);
      CSR_MINSTRETH, CSR_INSTRETH: val = XLEN'(instret_ext[63:32]);
      default: ;
    endcase
    return val;
  endfunction

  // WB write decode: RS/RC with zero source is a pure read and never writes
  always_comb begin
    op           = csr_op_e'(wr_op);
    wr_effective = rst && wr_en && (op != CSR_NONE) && ((op == CSR_RW) || (wr_src != '0));
    wr_commit    = wr_effective && csr_mapped(wr_addr) && !csr_ro(wr_addr);
    wr_bad       = wr_effective && (!csr_mapped(wr_addr) || csr_ro(wr_addr));
    wr_new       = XLEN'(csr_rmw(op, 64'(csr_value(wr_addr)), 64'(wr_src)));
    wr_vis       = (wr_addr == CSR_MCOUNTINHIBIT) ? (wr_new & XLEN'(5)) : wr_new;
    cnt_wdata    = (XLEN == 32) ? {wr_new[31:0], wr_new[31:0]} : 64'(wr_new);
    cyc_wr_lo    = wr_commit && (wr_addr == CSR_MCYCLE);
    ins_wr_lo    = wr_commit && (wr_addr == CSR_MINSTRET);
    cyc_wr_hi    = wr_commit && ((XLEN == 32) ? (wr_addr == CSR_MCYCLEH) : (wr_addr == CSR_MCYCLE));
    ins_wr_hi    = wr_commit && ((XLEN == 32) ? (wr_addr == CSR_MINSTRETH) : (wr_addr == CSR_MINSTRET));
  end

  // ID read with write-through from a same-address committing WB write
  always_comb begin
    rd_data    = '0;
    rd_illegal = 1'b0;
    if (rd_en) begin
      if (csr_mapped(rd_addr))
        rd_data = (wr_commit && (wr_addr == rd_addr)) ? wr_vis : csr_value(rd_addr);
      else
        rd_illegal = 1'b1;
    end
  end

  // Scratch registers and mcountinhibit CY/IR bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_reg[i] <= '0;
      inhibit_cy_reg <= 1'b0;
      inhibit_ir_reg <= 1'b0;
    end else if (wr_commit) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (wr_addr == SCRATCH_BASE + 12'(i)) scratch_reg[i] <= wr_new;
      if (wr_addr == CSR_MCOUNTINHIBIT) begin
        inhibit_cy_reg <= wr_new[0];
        inhibit_ir_reg <= wr_new[2];
      end
    end
  end

  // One-cycle pulse after an illegal write attempt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_illegal_reg <= 1'b0;
    else      wr_illegal_reg <= wr_bad;
  end

  assign wr_illegal = wr_illegal_reg;

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (1'b1),
    .inhibit (inhibit_cy_reg),
    .wr_lo   (cyc_wr_lo),
    .wr_hi   (cyc_wr_hi),
    .wr_data (CNT_WIDTH'(cnt_wdata)),
    .count   (cycle_cnt)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instret (
    .clk     (clk),
    .rst     (rst),
    .inc     (retire),
    .inhibit (inhibit_ir_reg),
    .wr_lo   (ins_wr_lo),
    .wr_hi   (ins_wr_hi),
    .wr_data (CNT_WIDTH'(cnt_wdata)),
    .count   (instret_cnt)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit (XLEN=32 defaults) with hand-computed values.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic [11:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_illegal;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [1:0]  wr_op = 2'b00;
  logic [31:0] wr_src = '0;
  logic        retire = 1'b0;
  logic        wr_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  csr_unit dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_illegal (rd_illegal),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_op      (wr_op),
    .wr_src     (wr_src),
    .retire     (retire),
    .wr_illegal (wr_illegal)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    rd_en   = 1'b1;
    rd_addr = addr;
    #1;
    check(tag, 64'(rd_data), exp);
    check({tag, "_ill"}, 64'(rd_illegal), 64'd0);
  endtask

  task automatic wr_set(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src);
    wr_en   = 1'b1;
    wr_op   = op;
    wr_addr = addr;
    wr_src  = src;
    $display("[%0t] wr op=%0d addr=0x%03h src=0x%08h", $time, op, addr, src);
  endtask

  task automatic wr_off();
    wr_en = 1'b0;
    wr_op = CSR_NONE;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rd_check("rst_mcycle", CSR_MCYCLE, 64'd0);
    check("rst_wr_illegal", 64'(wr_illegal), 64'd0);
    rst = 1'b1;

    // Ten free-running cycles, no retires
    repeat (10) tick();
    rd_check("mcycle_10", CSR_MCYCLE, 64'd10);
    rd_check("minstret_0", CSR_MINSTRET, 64'd0);
    rd_check("cycle_shadow", CSR_CYCLE, 64'd10);
    rd_check("mcycleh_0", CSR_MCYCLEH, 64'd0);

    // Scratch RMW sequence with bypass on the final RC
    wr_set(CSR_RW, 12'h341, 32'h0000_F0F0);
    tick();
    wr_set(CSR_RS, 12'h341, 32'h0000_000F);
    tick();
    wr_set(CSR_RC, 12'h341, 32'h0000_00F0);
    rd_check("scratch_bypass", 12'h341, 64'h0000_F00F);
    tick();
    wr_off();
    rd_check("scratch_341", 12'h341, 64'h0000_F00F);
    rd_check("scratch_340", 12'h340, 64'd0);
    rd_check("scratch_343", 12'h343, 64'd0);
    rd_en = 1'b1; rd_addr = 12'h344; #1;
    check("scratch_344_ill", 64'(rd_illegal), 64'd1);

    // Low-to-high carry within one increment
    wr_set(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    tick();
    wr_set(CSR_RW, CSR_MCYCLEH, 32'h0000_0000);
    tick();
    wr_off();
    rd_check("hiwr_keeps_lo", CSR_MCYCLE, 64'hFFFF_FFFF);
    rd_check("hiwr_hi", CSR_MCYCLEH, 64'd0);
    tick();
    rd_check("carry_lo", CSR_MCYCLE, 64'd0);
    rd_check("carry_hi", CSR_MCYCLEH, 64'd1);
    rd_check("carry_shadow_hi", CSR_CYCLEH, 64'd1);

    // Inhibit: write edge still counts with old inhibit, then frozen
    retire = 1'b1;
    wr_set(CSR_RW, CSR_MCOUNTINHIBIT, 32'h0000_0007);
    rd_check("inh_bypass", CSR_MCOUNTINHIBIT, 64'd5);
    tick();
    wr_off();
    rd_check("inh_readback", CSR_MCOUNTINHIBIT, 64'd5);
    repeat (4) tick();
    rd_check("frozen_mcycle", CSR_MCYCLE, 64'd1);
    rd_check("frozen_mcycleh", CSR_MCYCLEH, 64'd1);
    rd_check("frozen_minstret", CSR_MINSTRET, 64'd1);
    wr_set(CSR_RW, CSR_MCOUNTINHIBIT, 32'h0000_0000);
    tick();
    wr_off();
    rd_check("uninh_edge_mcycle", CSR_MCYCLE, 64'd1);
    rd_check("uninh_edge_minstret", CSR_MINSTRET, 64'd1);
    repeat (3) tick();
    rd_check("run_mcycle", CSR_MCYCLE, 64'd4);
    rd_check("run_minstret", CSR_MINSTRET, 64'd4);
    retire = 1'b0;

    // Illegal write to read-only shadow
    wr_set(CSR_RW, CSR_CYCLE, 32'h0000_0005);
    rd_check("ro_no_bypass", CSR_CYCLE, 64'd4);
    check("ill_before", 64'(wr_illegal), 64'd0);
    tick();
    wr_off();
    check("ill_pulse", 64'(wr_illegal), 64'd1);
    rd_check("ro_counter_kept", CSR_MCYCLE, 64'd5);
    tick();
    check("ill_one_cycle", 64'(wr_illegal), 64'd0);
    wr_set(CSR_RS, CSR_CYCLE, 32'h0000_0000);
    tick();
    wr_off();
    check("rs0_ro_legal", 64'(wr_illegal), 64'd0);
    rd_en = 1'b1; rd_addr = 12'h7FF; #1;
    check("unmapped_ill", 64'(rd_illegal), 64'd1);
    check("unmapped_data", 64'(rd_data), 64'd0);
    rd_en = 1'b0; rd_addr = CSR_MCYCLE; #1;
    check("rd_off_data", 64'(rd_data), 64'd0);
    check("rd_off_ill", 64'(rd_illegal), 64'd0);

    // Asynchronous reset mid-operation with a write pending
    wr_set(CSR_RW, 12'h7FF, 32'h0000_0001);
    tick();
    check("ill_unmapped_wr", 64'(wr_illegal), 64'd1);
    wr_set(CSR_RW, 12'h341, 32'h0000_0055);
    rst = 1'b0;
    #1;
    check("rst_clears_ill", 64'(wr_illegal), 64'd0);
    rd_check("rst_mcycle_now", CSR_MCYCLE, 64'd0);
    rd_check("rst_scratch_now", 12'h341, 64'd0);
    rd_check("rst_minstret_now", CSR_MINSTRET, 64'd0);
    repeat (2) tick();
    rd_check("rst_scratch_held", 12'h341, 64'd0);
    rd_check("rst_mcycle_held", CSR_MCYCLE, 64'd0);
    rst = 1'b1;
    wr_off();
    repeat (3) tick();
    rd_check("resume_mcycle", CSR_MCYCLE, 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised successor to the fixed single-file CSR block in the RV32I pipeline.
- Performs read-modify-write (RW/RS/RC) internally at WB, so EX needs no mask logic.
- Adds configurable scratch CSRs, 64-bit mcycle/minstret counters with mcountinhibit, read-only user shadows, and illegal-access detection.
- Read port is used in ID. Write port is driven from WB.

Parameters:
- XLEN, 32: data width; legal values are 32 and 64.
- NUM_SCRATCH, 4: number of general read/write CSRs (1..16).
- SCRATCH_BASE, 12'h340: address of scratch CSR 0; scratch i sits at SCRATCH_BASE+i.
- CNT_WIDTH, 64: width of the cycle and instret counters (33..64).

Ports:
- clk, input, 1: core clock.
- rst, input, 1: reset; asynchronous, active-low.
- rd_en, input, 1: ID-stage CSR read request.
- rd_addr, input, 12: CSR address read in ID.
- rd_data, output, XLEN: current CSR value, with write-through bypass.
- rd_illegal, output, 1: rd_en is high and rd_addr is unmapped.
- wr_en, input, 1: WB-stage CSR instruction valid.
- wr_addr, input, 12: destination CSR.
- wr_op, input, 2: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
- wr_src, input, XLEN: rs1 value or zero-extended zimm.
- retire, input, 1: one instruction retired this cycle.
- wr_illegal, output, 1: registered pulse flagging an illegal write attempt.

Behaviour:
- Reset (rst low, asynchronous): all scratch CSRs, mcountinhibit, both counters and wr_illegal go to 0.
- Address map:
  - scratch range.
  - 0x320 mcountinhibit: only bit0 (CY) and bit2 (IR) are writable; all other bits read 0.
  - 0xB00 / 0xB02: mcycle / minstret low word.
  - 0xB80 / 0xB82: high words; these exist only when XLEN=32.
  - 0xC00, 0xC02, 0xC80, 0xC82: read-only shadows of the counters.
  - Any other address is unmapped.
- When XLEN=64, 0xB00 and 0xC00 return the full counter, and all high-word addresses are unmapped.
- Counter bits at or above CNT_WIDTH read as 0.
- Read path is combinational, zero latency.
  - rd_data is 0 when rd_en is low or the address is unmapped.
  - rd_illegal = rd_en AND unmapped.
- Write-through bypass: if a legal write to the same address commits this cycle, rd_data returns the new value. This removes the ID/WB hazard.
- New value by op:
  - RW: new = wr_src.
  - RS: new = old | wr_src.
  - RC: new = old & ~wr_src.
  - old is the pre-edge value.
- Effective write: wr_en and op≠00, and one of:
  - op = RW, or
  - op = RS/RC with wr_src ≠ 0.
- RS/RC with wr_src = 0 is read-only: it performs no write and is legal even on read-only or counter-shadow addresses.
- Illegal write: an effective write to an unmapped or read-only (0xCxx) address.
  - No state changes.
  - wr_illegal is 1 on the next cycle, for exactly one cycle.
- Counters: each cycle,
  - mcycle += 1 unless mcountinhibit.CY = 1.
  - minstret += retire unless mcountinhibit.IR = 1.
  - Counters wrap modulo 2^CNT_WIDTH.
- Counter write in the same cycle as an increment: the write wins, with no increment on that edge.
  - A low-half write replaces bits [31:0] and keeps the high bits.
  - A high-half write replaces bits [CNT_WIDTH-1:32] and keeps the low bits.
- Carry from low to high across bit 31 happens within the single increment; no cycle of lag is allowed.
- Writing mcountinhibit takes effect from the edge after the write. The increment on the write edge itself uses the old inhibit value.
- Simultaneous rd/wr to different addresses: independent.
- Reset asserted mid-operation: all state clears immediately, regardless of wr_en.

Decomposition:
- Package csr_pkg holds:
  - localparams for all fixed CSR addresses.
  - the wr_op encoding (CSR_NONE, CSR_RW, CSR_RS, CSR_RC).
  - a function csr_rmw(op, old, src).
- One sub-module, csr_counter, instantiated twice (cycle, instret). It contains:
  - a CNT_WIDTH register.
  - inc and inhibit inputs.
  - wr_lo / wr_hi enables with a data input.
  - priority write over increment.

Test Plan:
- Reset, then run 10 cycles with retire = 0 → rd 0xB00 = 10, rd 0xB02 = 0; rd 0xC00 equals 0xB00.
- RW 0x341 ← 0xF0F0, RS with 0x000F, RC with 0x00F0 → read 0x341 = 0xF00F. Read 0x341 in the same cycle as the RC → 0xF00F via bypass.
- Write mcycle low = 0xFFFFFFFF, high = 0, inhibit 0 → one cycle later 0xB00 = 0, 0xB80 = 1.
- RW 0x320 ← 0x5, hold retire = 1 for 4 cycles → mcycle and minstret are frozen. Clear 0x320 → minstret advances by 1 per retire.
- RW 0xC00 ← 5 → wr_illegal = 1 for exactly one cycle, counter unchanged. RS 0xC00 with src 0 → wr_illegal stays 0. rd_addr 0x7FF → rd_illegal = 1, rd_data = 0.
- Assert rst with mcycle ≠ 0 and wr_en high → all CSRs read 0 immediately; counting resumes after release.
